// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the memory arbiter slice.
//   - owner_t    : which requester owns the response coming back next cycle
//   - MEM_SIZE_DEFAULT / WORD_BYTES : memory geometry defaults
//   - owner_of_gnt : maps a one-hot/zero grant vector to an owner_t
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned MEM_SIZE_DEFAULT = 256;
  localparam int unsigned WORD_BYTES       = 4;

  // Requester index order used by the arbiter grant vector.
  localparam int unsigned REQ_DATA   = 0;
  localparam int unsigned REQ_IFETCH = 1;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    DATA   = 2'd1,
    IFETCH = 2'd2
  } owner_t;

  // Grant vector is one-hot or zero; data has priority in the decode only
  // because both bits are never set together.
  function automatic owner_t owner_of_gnt(input logic [1:0] gnt);
    if (gnt[REQ_DATA])        return DATA;
    else if (gnt[REQ_IFETCH]) return IFETCH;
    else                      return NONE;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. Grant is combinational in the request
//   cycle; the register `last` remembers the most recent winner so that a tie
//   goes to the other requester. After reset `last` points at requester 1, so
//   requester 0 wins the first tie.
//
// Ports
//   clk  in      clock
//   rst  in      synchronous active-high reset (forces gnt = 0)
//   req  in  [1:0] request per requester
//   gnt  out [1:0] one-hot or zero grant
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // last_q = 1 : requester 1 was granted most recently.
  logic last_q;
  logic last_d;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      if (gnt != 2'b00) begin
        last_d = gnt[REQ_IFETCH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single access port of the byte memory between the data port
//   (requester 0, load/store) and the instruction-fetch port (requester 1,
//   read only). The winner drives the memory in the grant cycle; the memory
//   returns read data one cycle later, which is routed to the requester
//   recorded in the owner register. Word accesses whose last byte falls
//   outside the memory are still granted but have no memory effect and
//   respond with err = 1 and rdata = 0.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   d_req/d_we/d_wmask/d_addr/d_wdata  data-port request (wmask bit 3 = byte at addr)
//   d_gnt                          data request accepted this cycle
//   d_rvalid/d_rdata/d_err         data response (one cycle after d_gnt)
//   i_req/i_addr                   fetch request
//   i_gnt                          fetch accepted this cycle
//   i_rvalid/i_rdata/i_err         fetch response (one cycle after i_gnt)
//   mem_wr_en/mem_wr_mask/mem_addr/mem_wdata  memory port drive
//   mem_rdata                      memory read data (valid cycle after address)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  // memory port 0
  output logic              mem_wr_en,
  output logic [3:0]        mem_wr_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] gnt;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({i_req, d_req}),
    .gnt (gnt)
  );

  assign d_gnt = gnt[REQ_DATA];
  assign i_gnt = gnt[REQ_IFETCH];

  // ---------------------------------------------------------------------------
  // Winner address and legality
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W:0]   last_byte;   // one extra bit so addr + 3 cannot wrap
  logic              addr_legal;

  always_comb begin
    win_addr = '0;
    if (d_gnt) begin
      win_addr = d_addr;
    end else if (i_gnt) begin
      win_addr = i_addr;
    end
  end

  assign last_byte  = {1'b0, win_addr} + (ADDR_W+1)'(WORD_BYTES - 1);
  assign addr_legal = (last_byte < (ADDR_W+1)'(MEM_SIZE));

  // ---------------------------------------------------------------------------
  // Memory drive (grant cycle)
  // ---------------------------------------------------------------------------
  assign mem_addr    = win_addr;
  assign mem_wr_en   = d_gnt & d_we & addr_legal;
  assign mem_wr_mask = d_wmask;
  assign mem_wdata   = d_wdata;

  // ---------------------------------------------------------------------------
  // Outstanding response bookkeeping
  // ---------------------------------------------------------------------------
  owner_t owner_q, owner_d;
  logic   err_q,   err_d;

  assign owner_d = owner_of_gnt(gnt);
  assign err_d   = (gnt != 2'b00) & ~addr_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing (cycle after grant)
  //   A reset asserted in the response cycle drops the pending response, so
  //   the valid qualifiers are also gated with rst.
  // ---------------------------------------------------------------------------
  logic [31:0] resp_data;

  assign resp_data = err_q ? 32'h0 : mem_rdata;
  assign d_rvalid  = ~rst & (owner_q == DATA);
  assign i_rvalid  = ~rst & (owner_q == IFETCH);
  assign d_rdata   = d_rvalid ? resp_data : 32'h0;
  assign i_rdata   = i_rvalid ? resp_data : 32'h0;
  assign d_err     = d_rvalid & err_q;
  assign i_err     = i_rvalid & err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by random traffic. A byte-array memory device
//   sits on the memory port. The reference model keeps its own memory image
//   and round-robin state, predicts grants and memory drive each cycle, and
//   queues expected responses tagged with the cycle they are due; a monitor
//   compares them with what the DUT returns.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MEM_SIZE = 256;
  localparam int ADDR_W   = 32;

  logic              clk;
  logic              rst;
  logic              d_req, d_we;
  logic [3:0]        d_wmask;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid, i_err;
  logic [31:0]       i_rdata;
  logic              mem_wr_en;
  logic [3:0]        mem_wr_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_wmask    (d_wmask),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_err      (i_err),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_mask(mem_wr_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory device: registered read, byte-masked write, big-endian byte order
  // ---------------------------------------------------------------------------
  logic [7:0] mem_dev [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  function automatic bit legal(input logic [31:0] a);
    return (longint'(a) + 3) < longint'(MEM_SIZE);
  endfunction

  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = 32'hDEADBEEF;
    if (legal(mem_addr))
      rd = {mem_dev[mem_addr], mem_dev[mem_addr+1], mem_dev[mem_addr+2], mem_dev[mem_addr+3]};
    if (mem_wr_en && legal(mem_addr)) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_mask[3-b]) mem_dev[mem_addr+b] = mem_wdata[31-8*b -: 8];
    end
    mem_rdata <= rd;
  end

  // ---------------------------------------------------------------------------
  // Reference model: predicts grants and memory drive, queues responses
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          err;
    bit          chk_data;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  bit   last_was_i = 1'b1;

  always @(negedge clk) begin
    bit exp_dg, exp_ig, lg;
    logic [31:0] a;
    exp_t e;
    if (rst) begin
      check("d_gnt_in_rst", {31'b0, d_gnt}, 32'd0);
      check("i_gnt_in_rst", {31'b0, i_gnt}, 32'd0);
      last_was_i = 1'b1;
    end else begin
      if (d_req && i_req) begin
        exp_dg = last_was_i;
        exp_ig = !last_was_i;
      end else begin
        exp_dg = d_req;
        exp_ig = i_req;
      end
      check("d_gnt", {31'b0, d_gnt}, {31'b0, exp_dg});
      check("i_gnt", {31'b0, i_gnt}, {31'b0, exp_ig});
      if (exp_dg || exp_ig) begin
        a  = exp_dg ? d_addr : i_addr;
        lg = legal(a);
        check("mem_addr", mem_addr, a);
        check("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, exp_dg && d_we && lg});
        e.due      = cyc + 1;
        e.err      = !lg;
        e.data     = lg ? {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]} : 32'h0;
        e.chk_data = !(exp_dg && d_we && lg);
        if (exp_dg && d_we && lg) begin
          check("mem_wdata", mem_wdata, d_wdata);
          check("mem_wr_mask", {28'b0, mem_wr_mask}, {28'b0, d_wmask});
          for (int b = 0; b < 4; b++)
            if (d_wmask[3-b]) ref_mem[a+b] = d_wdata[31-8*b -: 8];
        end
        if (exp_dg) dq.push_back(e);
        else        iq.push_back(e);
        last_was_i = exp_ig;
      end else begin
        check("mem_addr_idle", mem_addr, 32'h0);
        check("mem_wr_en_idle", {31'b0, mem_wr_en}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT responses against queued expectations
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit   dv, iv;
    exp_t de, ie;
    dv = 1'b0;
    iv = 1'b0;
    if (!rst && dq.size() > 0 && dq[0].due == cyc) begin
      dv = 1'b1;
      de = dq.pop_front();
    end
    if (!rst && iq.size() > 0 && iq[0].due == cyc) begin
      iv = 1'b1;
      ie = iq.pop_front();
    end
    check("d_rvalid", {31'b0, d_rvalid}, {31'b0, dv});
    check("i_rvalid", {31'b0, i_rvalid}, {31'b0, iv});
    if (dv) begin
      check("d_err", {31'b0, d_err}, {31'b0, de.err});
      if (de.chk_data) check("d_rdata", d_rdata, de.data);
    end else begin
      check("d_rdata_idle", d_rdata, 32'h0);
    end
    if (iv) begin
      check("i_err", {31'b0, i_err}, {31'b0, ie.err});
      check("i_rdata", i_rdata, ie.data);
    end else begin
      check("i_rdata_idle", i_rdata, 32'h0);
    end
    if (rst) begin
      dq.delete();
      iq.delete();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b0;
    d_addr = '0; i_addr = '0; d_wmask = '0; d_wdata = '0;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      mem_dev[a+b] = w[31-8*b -: 8];
      ref_mem[a+b] = w[31-8*b -: 8];
    end
  endtask

  task automatic d_rd(input logic [31:0] a);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
  endtask

  task automatic d_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wmask = m; d_wdata = w;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'($urandom_range(MEM_SIZE - 6, MEM_SIZE + 3));
      default: return 32'($urandom_range(0, MEM_SIZE - 4));
    endcase
  endfunction

  initial begin
    for (int k = 0; k < MEM_SIZE; k++) begin
      mem_dev[k] = 8'($urandom);
      ref_mem[k] = mem_dev[k];
    end
    set_word(32'h40, 32'hfe010113);
    set_word(32'h44, 32'h00112e23);
    set_word(32'h48, 32'h00812c23);
    set_word(32'h80, 32'h11223344);
    set_word(32'hFC, 32'h55667788);

    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;

    // Single data read
    d_rd(32'h40);                  tick();
    idle();                        tick();

    // Fetch alone, then reset so the tie starts from data
    i_req = 1'b1; i_addr = 32'h44; tick();
    idle(); rst = 1'b1;            tick();
    rst = 1'b0;

    // Both requesting for four cycles: D, I, D, I
    d_rd(32'h40); i_req = 1'b1; i_addr = 32'h44;
    repeat (4) tick();
    idle();                        tick();

    // Partial write then read-after-write of the same word
    d_wr(32'h80, 4'b0011, 32'hAABBCCDD); tick();
    d_rd(32'h80);                  tick();
    idle();                        tick();

    // Illegal fetch, legal boundary write, wrap-around addresses
    i_req = 1'b1; i_addr = 32'hFD; tick();
    idle();
    d_wr(32'hFC, 4'b1111, 32'h0badf00d); tick();
    d_rd(32'hFC);                  tick();
    d_wr(32'hFFFFFFFE, 4'b1111, 32'h12345678); tick();
    idle(); i_req = 1'b1; i_addr = 32'hFFFFFFFE; tick();
    idle();                        tick();

    // Reset right after a grant drops the response; tie afterwards goes to data
    d_rd(32'h40); i_req = 1'b1; i_addr = 32'h44; tick();
    idle(); rst = 1'b1;            tick();
    rst = 1'b0;                    tick();
    d_rd(32'h44); i_req = 1'b1; i_addr = 32'h48; tick();
    idle();                        tick();

    // Back-to-back data reads
    d_rd(32'h40); tick();
    d_rd(32'h44); tick();
    d_rd(32'h48); tick();
    idle();       tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      d_req   = $urandom_range(0, 1);
      d_we    = $urandom_range(0, 1);
      d_wmask = 4'($urandom);
      d_wdata = $urandom;
      d_addr  = rand_addr();
      i_req   = $urandom_range(0, 1);
      i_addr  = rand_addr();
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (3) tick();

    check("d_queue_drained", 32'(dq.size()), 32'd0);
    check("i_queue_drained", 32'(iq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
